mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Parametrised memory-port arbiter that lets CHANNELS requestors share one synchronous-read memory port. It generalises the CPU-to-memory hookup from fixed, dedicated ports per requestor (instruction fetch, load/store) to N requestors with round-robin or fixed-priority arbitration. Each requestor gets a grant/read-valid handshake. It sits between the CPU (plus future DMA or debug masters) and one port of the dual-port RAM.

## Interface
Parameters:
- WIDTH, 16, data word width
- ADDR_WIDTH, 16, address width
- CHANNELS, 2, number of requestors (≥1)
- MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- req  in  CHANNELS  per-channel request
- we  in  CHANNELS  per-channel write enable (1 = store, 0 = load)
- addr  in  CHANNELS*ADDR_WIDTH  packed addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  CHANNELS*WIDTH  packed write data, channel i at [i*WIDTH +: WIDTH]
- gnt  out  CHANNELS  one-hot grant, combinational in the accept cycle
- rvalid  out  CHANNELS  one-hot read-data-valid, registered
- rdata  out  WIDTH  shared read data; meaningful only while any rvalid bit is set
- mem_addr  out  ADDR_WIDTH  address to memory port
- mem_wdata  out  WIDTH  write data to memory port
- mem_we  out  1  write enable to memory port
- mem_q  in  WIDTH  memory read data; valid one cycle after address (synchronous read)

## Operation
- Request rule: a requestor raises req[i] with we/addr/wdata stable. It holds them stable until gnt[i] is sampled high at a rising edge. At that edge it may drop or change the request.
- Grant selection: each cycle, among the asserted req bits, exactly one gnt bit is set (or none if no req). The selection is combinational from req and the priority pointer.
- MODE 0 (round-robin):
  - The pointer holds the channel with the highest priority.
  - On a grant to channel k, the pointer becomes (k+1) mod CHANNELS at the next edge.
  - With no grant, the pointer holds.
- MODE 1 (fixed priority): the lowest-index requesting channel wins. The pointer is unused.
- Memory drive:
  - mem_addr and mem_wdata are muxed from the granted channel.
  - mem_we = we[granted] & any grant.
  - With no grant: mem_we = 0, and mem_addr/mem_wdata hold the previous granted values (register the mux select, no X).
- Read return:
  - A granted read (we = 0) on channel k sets rvalid[k] = 1 for exactly the following cycle.
  - rdata = mem_q is passed through.
  - Writes never set rvalid.
- Back-to-back: one access is accepted every cycle, so throughput is one access per cycle. rvalid for the access accepted in cycle N appears in cycle N+1, concurrent with gnt for cycle N+1.
- Reset (reset == 0 at an edge):
  - pointer = 0, rvalid = 0, held mux select = 0.
  - While reset is low, gnt = 0 and mem_we = 0 (combinationally gated).
  - A read accepted in the cycle before reset asserts is dropped; its rvalid is not produced.
- CHANNELS = 1 degenerates to gnt[0] = req[0], with the pointer constant.

## Timing
- Accept latency: gnt is in the same cycle as req when the channel wins. Worst-case wait under full load in MODE 0 is CHANNELS-1 cycles.
- Read latency: rvalid and rdata arrive 1 cycle after gnt.
- Write: commits at the edge closing the gnt cycle.
- Simultaneous read-then-write, same address, different channels in consecutive cycles: the read returns the old data (memory read-before-write). The arbiter does no forwarding.
- A same-cycle write and read to one address are impossible through this block, since only one access is granted per cycle.
- Reset outputs: gnt = 0, rvalid = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0; rdata follows mem_q.
- Combinational path req→gnt→mem_addr must meet timing at the target clock; no other combinational paths from inputs to outputs except mem_q→rdata.

## Test plan
- Single read: CHANNELS = 2, MODE 0, memory preloaded [0x0010] = 0xBEEF; ch1 req read 0x0010 → gnt = 2'b10 in the same cycle, rvalid = 2'b10 with rdata = 0xBEEF the next cycle.
- Round-robin fairness: CHANNELS = 3, all req held for 6 cycles after reset → gnt sequence 001, 010, 100, 001, 010, 100.
- Fixed priority: MODE 1, ch0 and ch1 req continuously for 4 cycles → gnt = 01 every cycle; ch1 is granted only after ch0 drops.
- Write then read: ch0 writes 0x1234 to 0x0005 (no rvalid), then ch1 reads 0x0005 next cycle → rvalid[1] = 1, rdata = 0x1234.
- Reset mid-operation: read granted in cycle N, reset low in cycle N+1 → rvalid stays 0, gnt = 0, mem_we = 0 while reset is low; pointer = 0 after release.
- Idle hold: no req for 3 cycles after a write → mem_we = 0, gnt = 0, rvalid = 0, pointer unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates CHANNELS requestors onto one synchronous-read memory port.
// Round-robin or fixed-priority grant, one access per cycle, 1-cycle read return.
module mem_port_arbiter #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int CHANNELS   = 2,
    parameter int MODE       = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            req,
    input  logic [CHANNELS-1:0]            we,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] addr,
    input  logic [CHANNELS*WIDTH-1:0]      wdata,
    output logic [CHANNELS-1:0]            gnt,
    output logic [CHANNELS-1:0]            rvalid,
    output logic [WIDTH-1:0]               rdata,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [WIDTH-1:0]               mem_wdata,
    output logic                           mem_we,
    input  logic [WIDTH-1:0]               mem_q
);

    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         gidx;
    logic                  any_gnt;
    logic [CHANNELS-1:0]   rvalid_q, rvalid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    int                    cand;

    // Scan channels starting at the pointer (round-robin) or at 0 (fixed).
    always_comb begin
        any_gnt = 1'b0;
        gidx    = '0;
        cand    = 0;
        for (int off = 0; off < CHANNELS; off++) begin
            cand = (MODE == 0) ? int'(ptr_q) + off : off;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            if (reset && !any_gnt && req[cand]) begin
                any_gnt = 1'b1;
                gidx    = PW'(cand);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (any_gnt) begin
            gnt[gidx] = 1'b1;
        end
    end

    // Idle cycles keep driving the last granted address/data.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        if (any_gnt) begin
            addr_d  = addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_d = wdata[int'(gidx)*WIDTH +: WIDTH];
            mem_we  = we[gidx];
        end
        mem_addr  = addr_d;
        mem_wdata = wdata_d;
    end

    always_comb begin
        ptr_d    = ptr_q;
        rvalid_d = '0;
        if (any_gnt) begin
            if (MODE == 0) begin
                if (int'(gidx) == CHANNELS - 1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = gidx + 1'b1;
                end
            end
            if (!we[gidx]) begin
                rvalid_d[gidx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // A read accepted just before reset must not surface while reset is low.
    assign rvalid = rvalid_q & {CHANNELS{reset}};
    assign rdata  = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: 2-ch round-robin with a memory model,
// plus 3-ch round-robin and 2-ch fixed-priority instances for grant order.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [1:0]  req, we, gnt, rvalid;
    logic [31:0] addr, wdata;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_q;
    logic        mem_we;

    logic [2:0]  req3, we3, gnt3, rvalid3;
    logic [47:0] addr3, wdata3;
    logic [15:0] rdata3, maddr3, mwdata3;
    logic        mwe3;

    logic [1:0]  reqf, wef, gntf, rvalidf;
    logic [31:0] addrf, wdataf;
    logic [15:0] rdataf, maddrf, mwdataf;
    logic        mwef;

    mem_port_arbiter #(.WIDTH(16), .ADDR_WIDTH(16), .CHANNELS(2), .MODE(0)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_q(mem_q)
    );

    mem_port_arbiter #(.WIDTH(16), .ADDR_WIDTH(16), .CHANNELS(3), .MODE(0)) u_rr3 (
        .clk(clk), .reset(reset), .req(req3), .we(we3), .addr(addr3),
        .wdata(wdata3), .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3),
        .mem_addr(maddr3), .mem_wdata(mwdata3), .mem_we(mwe3),
        .mem_q(16'h0)
    );

    mem_port_arbiter #(.WIDTH(16), .ADDR_WIDTH(16), .CHANNELS(2), .MODE(1)) u_fp (
        .clk(clk), .reset(reset), .req(reqf), .we(wef), .addr(addrf),
        .wdata(wdataf), .gnt(gntf), .rvalid(rvalidf), .rdata(rdataf),
        .mem_addr(maddrf), .mem_wdata(mwdataf), .mem_we(mwef),
        .mem_q(16'h0)
    );

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    always @(posedge clk) begin
        mem_q <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    typedef struct {
        int          due;
        int          ch;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rvalid", {30'd0, rvalid}, 32'(1 << e.ch));
            chk("rdata", {16'd0, rdata}, {16'd0, e.data});
        end else begin
            chk("rv_idle", {30'd0, rvalid}, 32'd0);
        end
    end

    task automatic step(input logic [1:0] r, input logic [1:0] w,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input logic [1:0] eg);
        int          k;
        logic [15:0] ak, dk;
        req   = r;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
        @(negedge clk);
        chk("gnt", {30'd0, gnt}, {30'd0, eg});
        chk("mem_we", {31'd0, mem_we}, {31'd0, |(eg & w)});
        if (eg != 2'b00) begin
            k  = eg[1] ? 1 : 0;
            ak = k ? a1 : a0;
            dk = k ? d1 : d0;
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, ak});
            if (w[k]) begin
                chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, dk});
                ref_mem[ak] = dk;
            end else begin
                sb.push_back('{due: cyc + 1, ch: k, data: ref_mem[ak]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        req3 = '0; we3 = 3'b111; addr3 = '0; wdata3 = '0;
        reqf = '0; wef = 2'b11; addrf = '0; wdataf = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        mem[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
        mem[16'h0020] = 16'h5555; ref_mem[16'h0020] = 16'h5555;

        repeat (3) step(2'b11, 2'b11, 16'h0001, 16'h0002, 16'h1111, 16'h2222, 2'b00);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        req = '0;
        reset = 1'b1;

        req3 = 3'b111;
        reqf = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr3_gnt", {29'd0, gnt3}, 32'(1 << (i % 3)));
            chk("fp_gnt", {30'd0, gntf}, (i < 4) ? 32'd1 : 32'd2);
            @(posedge clk);
            #1;
            if (i == 3) reqf = 2'b10;
        end
        req3 = '0;
        reqf = '0;

        step(2'b10, 2'b00, 16'h0000, 16'h0010, 16'h0, 16'h0, 2'b10);
        step(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0, 16'h0, 2'b00);
        step(2'b01, 2'b01, 16'h0005, 16'h0000, 16'h1234, 16'h0, 2'b01);
        step(2'b10, 2'b00, 16'h0000, 16'h0005, 16'h0, 16'h0, 2'b10);
        step(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0, 16'h0, 2'b00);

        step(2'b11, 2'b00, 16'h0010, 16'h0005, 16'h0, 16'h0, 2'b01);
        step(2'b11, 2'b00, 16'h0010, 16'h0005, 16'h0, 16'h0, 2'b10);
        step(2'b11, 2'b00, 16'h0010, 16'h0005, 16'h0, 16'h0, 2'b01);

        step(2'b10, 2'b00, 16'h0000, 16'h0020, 16'h0, 16'h0, 2'b10);
        step(2'b01, 2'b01, 16'h0020, 16'h0000, 16'hAAAA, 16'h0, 2'b01);
        step(2'b10, 2'b00, 16'h0000, 16'h0020, 16'h0, 16'h0, 2'b10);

        step(2'b01, 2'b01, 16'h0030, 16'h0000, 16'h7777, 16'h0, 2'b01);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 2'b11, 16'h0040, 16'h0050, 16'h9999, 16'h8888, 2'b00);
            chk("hold_addr", {16'd0, mem_addr}, 32'h30);
            chk("hold_wdata", {16'd0, mem_wdata}, 32'h7777);
        end
        step(2'b11, 2'b00, 16'h0010, 16'h0020, 16'h0, 16'h0, 2'b10);

        step(2'b01, 2'b00, 16'h0010, 16'h0000, 16'h0, 16'h0, 2'b01);
        reset = 1'b0;
        sb.delete();
        step(2'b11, 2'b11, 16'h0060, 16'h0070, 16'h1, 16'h2, 2'b00);
        step(2'b11, 2'b11, 16'h0060, 16'h0070, 16'h1, 16'h2, 2'b00);
        reset = 1'b1;
        step(2'b11, 2'b00, 16'h0005, 16'h0010, 16'h0, 16'h0, 2'b01);
        step(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0, 16'h0, 2'b00);
        step(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0, 16'h0, 2'b00);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
